// File: rtl/acc_sched_if.sv
// Command, status and datapath-control bundle between the upstream
// controller (master) and the acc_sched run sequencer (slave).
interface acc_sched_if #(
   parameter int LEN_W  = 8,
   parameter int RCNT_W = 16
);
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic              din_valid;
   logic              sel;
   logic              acc_ce;
   logic              en;
   logic              busy;
   logic              done;
   logic              overrun;
   logic [RCNT_W-1:0] run_count;

   modport master (
      output start, len, abort, din_valid,
      input  sel, acc_ce, en, busy, done, overrun, run_count
   );

   modport slave (
      input  start, len, abort, din_valid,
      output sel, acc_ce, en, busy, done, overrun, run_count
   );
endinterface

// File: rtl/acc_sched.sv
// Run sequencer for the bias-preloaded accumulator datapath. Steers the
// bias mux (sel), accReg enable (acc_ce) and dout capture (en) so each run
// leaves dout = b + sum of exactly len valid samples, after a post-reset
// warm-up period. Reports busy/done/overrun and a saturating run count.
module acc_sched #(
   parameter int LEN_W  = 8,
   parameter int WARMUP = 4,
   parameter int RCNT_W = 16
) (
   input logic        clk,
   input logic        rst,
   acc_sched_if.slave bus
);
   typedef enum logic [1:0] {
      S_WARM = 2'd0,
      S_IDLE = 2'd1,
      S_RUN  = 2'd2
   } state_e;

   localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   state_e            state_q, state_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic [RCNT_W-1:0] run_count_q, run_count_d;

   logic              warm_last;
   logic              last_sample;

   // Warm-up ends on the WARMUP-th edge after reset release (first edge if 0).
   assign warm_last   = (WARMUP == 0) || (int'(warm_q) >= WARMUP - 1);
   assign last_sample = (cnt_q == len_q - LEN_W'(1));

   assign bus.done      = done_q;
   assign bus.overrun   = overrun_q;
   assign bus.run_count = run_count_q;

   // State register and run bookkeeping; reset abandons any partial run.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q     <= S_WARM;
         warm_q      <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         run_count_q <= '0;
      end else begin
         state_q     <= state_d;
         warm_q      <= warm_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         run_count_q <= run_count_d;
      end
   end

   // Next-state and Mealy datapath controls; abort overrides the sample path.
   always_comb begin
      // NOTE: every signal gets a default first so no branch can infer a latch.
      state_d     = state_q;
      warm_d      = warm_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      done_d      = 1'b0;
      overrun_d   = bus.start && (state_q != S_IDLE);
      run_count_d = run_count_q;
      bus.sel     = 1'b0;
      bus.acc_ce  = 1'b0;
      bus.en      = 1'b0;
      bus.busy    = 1'b1;

      unique case (state_q)
         S_WARM: begin
            if (warm_last) begin
               state_d = S_IDLE;
            end else begin
               warm_d = warm_q + WARM_W'(1);
            end
         end
         S_IDLE: begin
            bus.busy = 1'b0;
            // A zero-length command is silently ignored.
            if (bus.start && (bus.len != '0)) begin
               len_d   = bus.len;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.abort) begin
               state_d = S_IDLE;
            end else if (bus.din_valid) begin
               bus.acc_ce = 1'b1;
               bus.sel    = (cnt_q == '0);
               bus.en     = last_sample;
               cnt_d      = cnt_q + LEN_W'(1);
               if (last_sample) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  if (run_count_q != '1) begin
                     run_count_d = run_count_q + RCNT_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d = S_WARM;
         end
      endcase
   end
endmodule

// File: tb/tb_acc_sched.sv
// Self-checking bench for acc_sched: drives runs against a behavioural
// accumulator plant and compares controls, status and dout against
// expectations computed from the run rules with plain arithmetic.
module tb_acc_sched;
   localparam int LEN_W  = 8;
   localparam int WARMUP = 4;
   localparam int RCNT_W = 16;
   localparam int DW     = 22;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   acc_sched_if #(.LEN_W(LEN_W), .RCNT_W(RCNT_W)) bus ();

   acc_sched #(.LEN_W(LEN_W), .WARMUP(WARMUP), .RCNT_W(RCNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Accumulator datapath plant: bias mux, adder, accReg and dout register.
   logic [DW-1:0] b, din, acc_q, dout_q, adder;
   assign adder = (bus.sel ? b : acc_q) + din;

   // Plant registers, enabled by the sequencer's controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         dout_q <= '0;
      end else begin
         if (bus.acc_ce) acc_q  <= adder;
         if (bus.en)     dout_q <= adder;
      end
   end

   int            checks = 0;
   int            errors = 0;
   int            model_runs = 0;
   logic [DW-1:0] model_dout = '0;
   logic [DW-1:0] din_tbl [8];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [LEN_W-1:0] l, input logic a,
                        input logic v, input logic [DW-1:0] d);
      bus.start     = s;
      bus.len       = l;
      bus.abort     = a;
      bus.din_valid = v;
      din           = d;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Release reset, start during warm-up (must overrun), then expect IDLE after WARMUP edges.
   task automatic warm_up();
      drive(0, '0, 0, 0, '0);
      rst = 1'b0;
      tick();
      check("warm_busy_e1", bus.busy, 1);
      drive(1, LEN_W'(3), 0, 0, '0);
      tick();
      check("warm_overrun", bus.overrun, 1);
      check("warm_busy_e2", bus.busy, 1);
      drive(0, '0, 0, 0, '0);
      tick();
      check("warm_overrun_clr", bus.overrun, 0);
      check("warm_busy_e3", bus.busy, 1);
      tick();
      check("warm_busy_e4", bus.busy, 0);
      check("warm_run_count", bus.run_count, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         drive(0, '0, 0, 0, '0);
         check("idle_busy", bus.busy, 0);
         check("idle_done", bus.done, 0);
         check("idle_overrun", bus.overrun, 0);
      end
   endtask

   // One run: start in the current cycle, feed n valid samples (vmask gives
   // valid per cycle for the first 32 cycles, valid afterwards), optionally
   // abort on valid sample abort_at or assert reset on sample rst_at.
   task automatic run(input int n, input logic [DW-1:0] bias, input logic [31:0] vmask,
                      input bit use_tbl, input int abort_at, input int rst_at,
                      input bit rand_start);
      logic [DW-1:0] sum, d;
      int            k, cyc;
      bit            v, ab, s, prev_s, aborted;
      b       = bias;
      sum     = bias;
      k       = 0;
      cyc     = 0;
      prev_s  = 1'b0;
      aborted = 1'b0;
      drive(1, LEN_W'(n), 0, 0, '0);
      check("start_busy", bus.busy, 0);
      tick();
      while (k < n) begin
         v  = (cyc < 32) ? vmask[cyc] : 1'b1;
         ab = v && (k == abort_at);
         s  = rand_start && ($urandom_range(0, 3) == 0);
         d  = use_tbl ? din_tbl[k % 8] : DW'($urandom);
         drive(s, '0, ab, v, d);
         check("run_busy", bus.busy, 1);
         check("run_done_low", bus.done, 0);
         check("run_overrun", bus.overrun, prev_s);
         check("run_sel", bus.sel, v && !ab && (k == 0));
         check("run_acc_ce", bus.acc_ce, v && !ab);
         check("run_en", bus.en, v && !ab && (k == n - 1));
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            model_runs = 0;
            model_dout = '0;
            check("rst_sel", bus.sel, 0);
            check("rst_acc_ce", bus.acc_ce, 0);
            check("rst_en", bus.en, 0);
            check("rst_busy", bus.busy, 1);
            check("rst_done", bus.done, 0);
            check("rst_overrun", bus.overrun, 0);
            check("rst_run_count", bus.run_count, 0);
            check("rst_dout", dout_q, model_dout);
            return;
         end
         prev_s = s;
         tick();
         cyc++;
         if (ab) begin
            aborted = 1'b1;
            break;
         end
         if (v) begin
            sum = sum + d;
            k++;
         end
      end
      drive(0, '0, 0, 0, '0);
      check("end_overrun", bus.overrun, prev_s);
      check("end_busy", bus.busy, 0);
      if (aborted) begin
         check("abort_done", bus.done, 0);
      end else begin
         if (model_runs < (1 << RCNT_W) - 1) model_runs++;
         model_dout = sum;
         check("run_done", bus.done, 1);
      end
      check("end_dout", dout_q, model_dout);
      check("end_run_count", bus.run_count, model_runs);
   endtask

   initial begin
      int n, ab_at;
      rst           = 1'b1;
      b             = '0;
      din           = '0;
      bus.start     = 1'b0;
      bus.len       = '0;
      bus.abort     = 1'b0;
      bus.din_valid = 1'b0;
      for (int i = 0; i < 8; i++) din_tbl[i] = '0;

      // Reset values.
      @(negedge clk);
      #1;
      check("reset_busy", bus.busy, 1);
      check("reset_sel", bus.sel, 0);
      check("reset_acc_ce", bus.acc_ce, 0);
      check("reset_en", bus.en, 0);
      check("reset_done", bus.done, 0);
      check("reset_overrun", bus.overrun, 0);
      check("reset_run_count", bus.run_count, 0);
      tick();
      warm_up();

      // len=3, din 10,20,30, b=-5 started at the first IDLE cycle.
      din_tbl[0] = DW'(10);
      din_tbl[1] = DW'(20);
      din_tbl[2] = DW'(30);
      run(3, DW'(-5), '1, 1, -1, -1, 0);
      check("dout_55", dout_q, 55);
      check("run_count_1", bus.run_count, 1);
      idle(1);

      // len=4 with valid pattern 1,0,0,1,1,0,1.
      run(4, DW'($urandom), 32'h0000_0059, 0, -1, -1, 0);
      idle(1);

      // len=1, din=7, b=3: sel and en together.
      din_tbl[0] = DW'(7);
      run(1, DW'(3), '1, 1, -1, -1, 0);
      check("dout_10", dout_q, 10);

      // len=0 start is ignored.
      tick();
      drive(1, '0, 0, 0, '0);
      check("len0_busy_before", bus.busy, 0);
      tick();
      drive(0, '0, 0, 0, '0);
      check("len0_busy_after", bus.busy, 0);
      check("len0_overrun", bus.overrun, 0);
      idle(1);

      // len=5 aborted on the 5th valid sample, then restart next cycle.
      run(5, DW'($urandom), '1, 0, 4, -1, 0);
      run(3, DW'($urandom), '1, 0, -1, -1, 0);

      // Randomized runs: stalls, stray starts, occasional aborts, random gaps.
      for (int r = 0; r < 30; r++) begin
         n     = $urandom_range(1, 12);
         ab_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
         run(n, DW'($urandom), $urandom, 0, ab_at, -1, 1);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end

      // Maximum run length.
      idle(1);
      run((1 << LEN_W) - 1, DW'($urandom), '1, 0, -1, -1, 0);

      // Back-to-back runs, second one cut by reset.
      run(4, DW'($urandom), '1, 0, -1, -1, 0);
      run(6, DW'($urandom), '1, 0, -1, 3, 0);
      tick();
      warm_up();
      run(2, DW'($urandom), '1, 0, -1, -1, 0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/acc_sched.md
Name: acc_sched

Overview:
Run sequencer for the 22-bit bias-preloaded accumulator datapath (acc_adder + accReg + bias mux + dout register).
- Accepts a start/length command and a per-sample valid.
- Drives the datapath's bias-select (sel), accumulator clock-enable (acc_ce) and output-capture enable (en) so that each run produces dout = b + sum of exactly len samples.
- Enforces a post-reset pipeline warm-up.
- Reports busy, done, overrun and a completed-run count to the upstream controller.

Parameters:
- LEN_W, 8: width of run-length field and sample counter; max run length 2^LEN_W-1.
- WARMUP, 4: cycles after reset release before any start is accepted.
- RCNT_W, 16: width of completed-run counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- len  in  LEN_W  samples per run; captured with start.
- abort  in  1  synchronous run cancel.
- din_valid  in  1  current din sample valid this cycle.
- sel  out  1  1 = mux selects sign-extended bias b (first sample of run), 0 = accReg.
- acc_ce  out  1  clock enable for accReg.
- en  out  1  dout capture enable (last sample of run).
- busy  out  1  high in WARM and RUN.
- done  out  1  one-cycle pulse; dout holds the finished result.
- overrun  out  1  one-cycle pulse; start arrived while not IDLE.
- run_count  out  RCNT_W  completed runs, saturating.

Behaviour:
- Reset (async, rst=1): state=WARM, warm counter=0, sample counter=0, len_q=0, done=0, overrun=0, run_count=0. Combinational outputs sel/acc_ce/en=0, busy=1.
- States: WARM, IDLE, RUN.
- WARM:
  - Counts clk edges after rst deasserts; after WARMUP cycles go to IDLE.
  - With WARMUP=0, go directly to IDLE on the first edge.
  - start ignored; overrun pulses.
- IDLE:
  - busy=0.
  - start=1 and len!=0: len_q<=len, cnt<=0, go to RUN.
  - start=1 and len==0: ignored, stay IDLE, no pulse.
- RUN (Mealy outputs, same-cycle with din_valid so the datapath edge sees them):
  - acc_ce = din_valid.
  - sel = din_valid & (cnt==0).
  - en = din_valid & (cnt==len_q-1).
  - On din_valid: cnt<=cnt+1.
  - On the last valid sample: go to IDLE; done<=1 the next cycle; run_count<=run_count+1, saturating at all-ones.
  - din_valid=0: stall. acc_ce=sel=en=0; accReg holds; cnt holds; no timeout.
  - len_q=1: sel and en asserted in the same cycle; dout=b+din.
- Latency: done is high in the cycle after the en cycle, which is the first cycle the new dout is visible.
- Back-to-back: start is accepted in the done cycle (state is already IDLE). The next RUN begins the following cycle. Minimum gap between runs is one IDLE cycle.
- abort=1 in RUN:
  - Go to IDLE immediately.
  - Outputs forced 0 that cycle, even if din_valid=1 and it is the last sample.
  - No en, no done, run_count unchanged; dout retains the previous result.
  - abort in WARM/IDLE has no effect. abort beats start in the same cycle.
- overrun: registered one-cycle pulse the cycle after start=1 while state!=IDLE. The command is dropped; the current run is unaffected.
- Reset mid-run: everything returns to reset values asynchronously; the partial sum is abandoned; WARM restarts.
- done and overrun are registered; busy is decoded from the state register.

Test Plan:
- Reset, then start at the first IDLE cycle with WARMUP=4 -> busy low exactly 4 cycles after rst falls; start while busy -> overrun one pulse, no RUN.
- len=3, din_valid continuous, din=10,20,30, b=-5 -> sel only on sample 1, en only on sample 3, done next cycle, dout=55, run_count=1.
- len=4 with din_valid pattern 1,0,0,1,1,0,1 -> acc_ce mirrors valid, en on the 7th cycle, dout=b+sum of the 4 valid samples.
- len=1, din=7, b=3 -> sel and en in the same cycle, dout=10; then len=0 start -> ignored, state stays IDLE.
- len=5, abort asserted with the 5th valid sample -> no en, no done, dout unchanged, run_count unchanged; a new start in the next cycle is accepted.
- Back-to-back: start asserted in the done cycle -> second run begins with sel on its first sample; rst pulsed mid-second-run -> all outputs 0 immediately, busy=1, run_count=0.
